// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS control path: opcodes, functs, ALU codes,
// FSM states, trap codes, datapath selects and the control-line bundle.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_SLL   = 6'b000000;
   localparam logic [5:0] FN_SRL   = 6'b000010;
   localparam logic [5:0] FN_SRA   = 6'b000011;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_ADDU = 4'b1000;
   localparam logic [3:0] ALU_XOR  = 4'b1010;
   localparam logic [3:0] ALU_SLTU = 4'b1011;
   localparam logic [3:0] ALU_LUI  = 4'b1110;
   localparam logic [3:0] ALU_FUNC = 4'b1111;

   localparam logic [1:0] SRCA_PC      = 2'b00;
   localparam logic [1:0] SRCA_RS      = 2'b01;
   localparam logic [1:0] SRCA_SHAMT   = 2'b10;
   localparam logic [1:0] SRCB_RT      = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      ST_FETCH   = 4'd0,
      ST_DECODE  = 4'd1,
      ST_MEMADDR = 4'd2,
      ST_MEMRD   = 4'd3,
      ST_MEMWB   = 4'd4,
      ST_MEMWR   = 4'd5,
      ST_EXEC    = 4'd6,
      ST_ALUWB   = 4'd7,
      ST_BRANCH  = 4'd8,
      ST_JUMP    = 4'd9,
      ST_TRAP    = 4'd10
   } state_e;

   typedef enum logic [1:0] {
      TRAP_NONE    = 2'b00,
      TRAP_ILLEGAL = 2'b01,
      TRAP_TIMEOUT = 2'b10
   } trap_e;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       branch_ne;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic       sign_extend;
   } ctrl_t;

endpackage

// File: rtl/alu_op_decode.sv
// Opcode/funct to ALU control: ALU operation, immediate extension and shift-amount select.
module alu_op_decode
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned OPCODE_W = 6,
   parameter int unsigned FUNC_W   = 6,
   parameter int unsigned ALUOP_W  = 4
) (
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [FUNC_W-1:0]   func,
   output logic [ALUOP_W-1:0]  alu_op,
   output logic                sign_ext,
   output logic                shift_sel,
   output logic                is_alu
);

   always_comb begin
      alu_op    = ALUOP_W'(ALU_ADD);
      sign_ext  = 1'b0;
      shift_sel = 1'b0;
      is_alu    = 1'b1;
      case (opcode)
         OPCODE_W'(OP_RTYPE): begin
            alu_op    = ALUOP_W'(ALU_FUNC);
            shift_sel = (func == FUNC_W'(FN_SLL)) || (func == FUNC_W'(FN_SRL)) ||
                        (func == FUNC_W'(FN_SRA));
         end
         OPCODE_W'(OP_ADDI):  begin alu_op = ALUOP_W'(ALU_ADD);  sign_ext = 1'b1; end
         OPCODE_W'(OP_SLTI):  begin alu_op = ALUOP_W'(ALU_SLT);  sign_ext = 1'b1; end
         OPCODE_W'(OP_SLTIU): begin alu_op = ALUOP_W'(ALU_SLTU); sign_ext = 1'b1; end
         OPCODE_W'(OP_ADDIU): alu_op = ALUOP_W'(ALU_ADDU);
         OPCODE_W'(OP_ANDI):  alu_op = ALUOP_W'(ALU_AND);
         OPCODE_W'(OP_ORI):   alu_op = ALUOP_W'(ALU_OR);
         OPCODE_W'(OP_XORI):  alu_op = ALUOP_W'(ALU_XOR);
         OPCODE_W'(OP_LUI):   alu_op = ALUOP_W'(ALU_LUI);
         default:             is_alu = 1'b0;
      endcase
   end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing
// with memory-ready stalls, optional BNE, illegal-opcode and memory-timeout traps.
module multi_cycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned OPCODE_W    = 6,
   parameter int unsigned FUNC_W      = 6,
   parameter int unsigned ALUOP_W     = 4,
   parameter int unsigned SUPPORT_BNE = 1,
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned WAIT_W      = 5
) (
   input  logic                CLK,
   input  logic                Reset_L,
   input  logic [OPCODE_W-1:0] Opcode,
   input  logic [FUNC_W-1:0]   Func,
   input  logic                MemReady,
   output logic                PCWrite,
   output logic                PCWriteCond,
   output logic                BranchNE,
   output logic                IorD,
   output logic                MemRead,
   output logic                MemWrite,
   output logic                IRWrite,
   output logic                MemToReg,
   output logic                RegDst,
   output logic                RegWrite,
   output logic [1:0]          ALUSrcA,
   output logic [1:0]          ALUSrcB,
   output logic [1:0]          PCSource,
   output logic                SignExtend,
   output logic [ALUOP_W-1:0]  ALUOp,
   output logic [1:0]          Trap,
   output logic [3:0]          State
);

   state_e              state, state_n;
   trap_e               trap_q, trap_n;
   logic [WAIT_W-1:0]   wcnt, wcnt_n, wcnt_inc;
   logic                run_q;
   ctrl_t               ctrl;
   logic [ALUOP_W-1:0]  alu_op;

   logic [ALUOP_W-1:0]  dec_alu_op;
   logic                dec_sign_ext, dec_shift_sel, dec_is_alu;
   logic                is_rtype, is_lw, is_sw, is_beq, is_bne, is_j;
   logic                mem_state, timeout_hit;

   alu_op_decode #(
      .OPCODE_W (OPCODE_W),
      .FUNC_W   (FUNC_W),
      .ALUOP_W  (ALUOP_W)
   ) u_alu_op_decode (
      .opcode    (Opcode),
      .func      (Func),
      .alu_op    (dec_alu_op),
      .sign_ext  (dec_sign_ext),
      .shift_sel (dec_shift_sel),
      .is_alu    (dec_is_alu)
   );

   assign is_rtype = (Opcode == OPCODE_W'(OP_RTYPE));
   assign is_lw    = (Opcode == OPCODE_W'(OP_LW));
   assign is_sw    = (Opcode == OPCODE_W'(OP_SW));
   assign is_beq   = (Opcode == OPCODE_W'(OP_BEQ));
   assign is_bne   = (SUPPORT_BNE != 0) && (Opcode == OPCODE_W'(OP_BNE));
   assign is_j     = (Opcode == OPCODE_W'(OP_J));

   // A wait cycle that would bring the counter to the limit traps; MemReady in that cycle wins.
   assign mem_state   = (state == ST_FETCH) || (state == ST_MEMRD) || (state == ST_MEMWR);
   assign wcnt_inc    = wcnt + WAIT_W'(1);
   assign timeout_hit = (MEM_TIMEOUT != 0) && (wcnt_inc == WAIT_W'(MEM_TIMEOUT));

   // run_q holds the FSM and its outputs idle until the first edge after reset release.
   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         state  <= ST_FETCH;
         trap_q <= TRAP_NONE;
         wcnt   <= '0;
         run_q  <= 1'b0;
      end else begin
         state  <= state_n;
         trap_q <= trap_n;
         wcnt   <= wcnt_n;
         run_q  <= 1'b1;
      end
   end

   always_comb begin
      state_n = state;
      trap_n  = trap_q;
      if (run_q) begin
         case (state)
            ST_FETCH, ST_MEMRD, ST_MEMWR: begin
               if (MemReady) begin
                  state_n = (state == ST_FETCH) ? ST_DECODE :
                            (state == ST_MEMRD) ? ST_MEMWB  : ST_FETCH;
               end else if (timeout_hit) begin
                  state_n = ST_TRAP;
                  trap_n  = TRAP_TIMEOUT;
               end
            end
            ST_DECODE: begin
               if (is_lw || is_sw)        state_n = ST_MEMADDR;
               else if (dec_is_alu)       state_n = ST_EXEC;
               else if (is_beq || is_bne) state_n = ST_BRANCH;
               else if (is_j)             state_n = ST_JUMP;
               else begin
                  state_n = ST_TRAP;
                  trap_n  = TRAP_ILLEGAL;
               end
            end
            ST_MEMADDR: state_n = is_sw ? ST_MEMWR : ST_MEMRD;
            ST_EXEC:    state_n = ST_ALUWB;
            ST_TRAP:    state_n = ST_TRAP;
            default:    state_n = ST_FETCH;
         endcase
      end
   end

   // Counter restarts on every state change and on MemReady; counts only stalled memory cycles.
   always_comb begin
      wcnt_n = '0;
      if (run_q && mem_state && (state_n == state)) wcnt_n = wcnt_inc;
   end

   always_comb begin
      ctrl   = '0;
      alu_op = '0;
      if (run_q) begin
         case (state)
            ST_FETCH: begin
               ctrl.mem_read  = 1'b1;
               ctrl.alu_src_a = SRCA_PC;
               ctrl.alu_src_b = SRCB_FOUR;
               ctrl.pc_source = PCSRC_ALU;
               ctrl.ir_write  = MemReady;
               ctrl.pc_write  = MemReady;
               alu_op         = ALUOP_W'(ALU_ADD);
            end
            ST_DECODE: begin
               ctrl.alu_src_a   = SRCA_PC;
               ctrl.alu_src_b   = SRCB_IMM_SH2;
               ctrl.sign_extend = 1'b1;
               alu_op           = ALUOP_W'(ALU_ADD);
            end
            ST_MEMADDR: begin
               ctrl.alu_src_a   = SRCA_RS;
               ctrl.alu_src_b   = SRCB_IMM;
               ctrl.sign_extend = 1'b1;
               alu_op           = ALUOP_W'(ALU_ADD);
            end
            ST_MEMRD: begin
               ctrl.iord     = 1'b1;
               ctrl.mem_read = 1'b1;
            end
            ST_MEMWB: begin
               ctrl.mem_to_reg = 1'b1;
               ctrl.reg_write  = 1'b1;
            end
            ST_MEMWR: begin
               ctrl.iord      = 1'b1;
               ctrl.mem_write = 1'b1;
            end
            ST_EXEC: begin
               alu_op           = dec_alu_op;
               ctrl.sign_extend = dec_sign_ext;
               if (is_rtype) begin
                  ctrl.alu_src_a = dec_shift_sel ? SRCA_SHAMT : SRCA_RS;
                  ctrl.alu_src_b = SRCB_RT;
               end else begin
                  ctrl.alu_src_a = SRCA_RS;
                  ctrl.alu_src_b = SRCB_IMM;
               end
            end
            ST_ALUWB: begin
               ctrl.reg_write = 1'b1;
               ctrl.reg_dst   = is_rtype;
            end
            ST_BRANCH: begin
               ctrl.alu_src_a     = SRCA_RS;
               ctrl.alu_src_b     = SRCB_RT;
               ctrl.pc_write_cond = 1'b1;
               ctrl.pc_source     = PCSRC_ALUOUT;
               ctrl.branch_ne     = is_bne;
               alu_op             = ALUOP_W'(ALU_SUB);
            end
            ST_JUMP: begin
               ctrl.pc_write  = 1'b1;
               ctrl.pc_source = PCSRC_JUMP;
            end
            default: ;
         endcase
      end
   end

   assign PCWrite     = ctrl.pc_write;
   assign PCWriteCond = ctrl.pc_write_cond;
   assign BranchNE    = ctrl.branch_ne;
   assign IorD        = ctrl.iord;
   assign MemRead     = ctrl.mem_read;
   assign MemWrite    = ctrl.mem_write;
   assign IRWrite     = ctrl.ir_write;
   assign MemToReg    = ctrl.mem_to_reg;
   assign RegDst      = ctrl.reg_dst;
   assign RegWrite    = ctrl.reg_write;
   assign ALUSrcA     = ctrl.alu_src_a;
   assign ALUSrcB     = ctrl.alu_src_b;
   assign PCSource    = ctrl.pc_source;
   assign SignExtend  = ctrl.sign_extend;
   assign ALUOp       = alu_op;
   assign Trap        = trap_q;
   assign State       = state;

endmodule
